// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - APB4 requester: one valid/ready command becomes one SETUP/ACCESS transfer
// Every output is a flop loaded from the next-state decode, so PREADY never reaches an output combinationally.
module apb_master_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                PCLK,
   input  logic                PRESET,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_strb,
   input  logic [2:0]          cmd_prot,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_slverr,
   output logic                rsp_timeout,
   output logic [ADDR_W-1:0]   PADDR,
   output logic [2:0]          PPROT,
   output logic                PSELx,
   output logic                PENABLE,
   output logic                PWRITE,
   output logic [DATA_W-1:0]   PWDATA,
   output logic [DATA_W/8-1:0] PSTRB,
   input  logic                PREADY,
   input  logic [DATA_W-1:0]   PRDATA,
   input  logic                PSLVERR
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] wait_cnt, wait_inc;
   logic             accept, timeout_hit;

   // The limit cycle itself aborts unless PREADY is high in it, so ACCESS lasts at most TIMEOUT cycles.
   always_comb begin
      accept      = cmd_valid & cmd_ready;
      wait_inc    = (&wait_cnt) ? wait_cnt : wait_cnt + CNT_ONE;
      timeout_hit = (TIMEOUT > 0) && !PREADY && (wait_inc >= CNT_LIMIT);
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (accept) state_nxt = S_SETUP;
         S_SETUP:  state_nxt = S_ACCESS;
         S_ACCESS: if (PREADY || timeout_hit) state_nxt = S_RESP;
         S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         cmd_ready   <= 1'b1;
         PSELx       <= 1'b0;
         PENABLE     <= 1'b0;
         rsp_valid   <= 1'b0;
         PADDR       <= '0;
         PPROT       <= '0;
         PWRITE      <= 1'b0;
         PWDATA      <= '0;
         PSTRB       <= '0;
         rsp_rdata   <= '0;
         rsp_slverr  <= 1'b0;
         rsp_timeout <= 1'b0;
         wait_cnt    <= '0;
      end else begin
         cmd_ready <= (state_nxt == S_IDLE);
         PSELx     <= (state_nxt == S_SETUP) || (state_nxt == S_ACCESS);
         PENABLE   <= (state_nxt == S_ACCESS);
         rsp_valid <= (state_nxt == S_RESP);
         // APB fields load only on accept, so they hold their last values between transfers.
         if (accept) begin
            PADDR    <= cmd_addr;
            PPROT    <= cmd_prot;
            PWRITE   <= cmd_write;
            PWDATA   <= cmd_write ? cmd_wdata : '0;
            PSTRB    <= cmd_write ? cmd_strb : '0;
            wait_cnt <= '0;
         end
         if (state == S_ACCESS) begin
            if (PREADY) begin
               rsp_rdata   <= PWRITE ? '0 : PRDATA;
               rsp_slverr  <= PSLVERR;
               rsp_timeout <= 1'b0;
            end else begin
               wait_cnt <= wait_inc;
               if (timeout_hit) begin
                  rsp_rdata   <= '0;
                  rsp_slverr  <= 1'b1;
                  rsp_timeout <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - randomized self-checking bench for apb_master_bridge
// Expected outputs come from a per-transaction timeline: 1 SETUP cycle, N ACCESS cycles, then RESP until handshake.
`timescale 1ns/1ps
module tb_apb_master_bridge;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int SW  = DW / 8;
   localparam int TMO = 4;

   logic          PCLK = 1'b0;
   logic          PRESET = 1'b1;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [SW-1:0] cmd_strb;
   logic [2:0]    cmd_prot;
   logic          rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
   logic [DW-1:0] rsp_rdata;
   logic [AW-1:0] PADDR;
   logic [2:0]    PPROT;
   logic          PSELx, PENABLE, PWRITE, PREADY, PSLVERR;
   logic [DW-1:0] PWDATA, PRDATA;
   logic [SW-1:0] PSTRB;

   apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
      .PADDR(PADDR), .PPROT(PPROT), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   int          n_tests = 0;
   int          n_fail  = 0;
   int unsigned cyc = 0;
   always @(posedge PCLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
      end
   endtask

   logic          e_cmd_ready, e_psel, e_pen, e_rsp_valid, e_pwrite, e_slverr, e_to;
   logic [AW-1:0] e_paddr;
   logic [DW-1:0] e_pwdata, e_rdata;
   logic [SW-1:0] e_pstrb;
   logic [2:0]    e_pprot;

   int unsigned   pen_total = 0, rd_strb_bad = 0, rsp_rise_cyc = 0;
   logic          prev_rsp_valid = 1'b0;
   logic [DW-1:0] obs_rdata = '0;
   logic          obs_slverr = 1'b0, obs_to = 1'b0;

   always @(negedge PCLK) begin
      check("cmd_ready", cmd_ready, e_cmd_ready);
      check("PSELx", PSELx, e_psel);
      check("PENABLE", PENABLE, e_pen);
      check("rsp_valid", rsp_valid, e_rsp_valid);
      check("PADDR", PADDR, e_paddr);
      check("PWRITE", PWRITE, e_pwrite);
      check("PWDATA", PWDATA, e_pwdata);
      check("PSTRB", PSTRB, e_pstrb);
      check("PPROT", PPROT, e_pprot);
      if (e_rsp_valid) begin
         check("rsp_rdata", rsp_rdata, e_rdata);
         check("rsp_slverr", rsp_slverr, e_slverr);
         check("rsp_timeout", rsp_timeout, e_to);
      end
      if (PENABLE) pen_total++;
      if (PSELx && !PWRITE && PSTRB != '0) rd_strb_bad++;
      if (rsp_valid && !prev_rsp_valid) begin
         rsp_rise_cyc = cyc;
         obs_rdata    = rsp_rdata;
         obs_slverr   = rsp_slverr;
         obs_to       = rsp_timeout;
      end
      prev_rsp_valid = rsp_valid;
   end

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic junk();
      PREADY  = 1'($urandom);
      PSLVERR = 1'($urandom);
      PRDATA  = $urandom;
   endtask

   task automatic set_exp(input logic cr, input logic ps, input logic pe, input logic rv);
      e_cmd_ready = cr;
      e_psel      = ps;
      e_pen       = pe;
      e_rsp_valid = rv;
   endtask

   task automatic set_fields(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                             input logic [SW-1:0] strb, input logic [2:0] prot);
      e_paddr  = addr;
      e_pwrite = wr;
      e_pwdata = wr ? wdata : '0;
      e_pstrb  = wr ? strb : '0;
      e_pprot  = prot;
   endtask

   int unsigned acc_cyc, pen_mark;

   task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [SW-1:0] strb, input logic [2:0] prot, input logic [DW-1:0] rdata,
                          input logic serr, input int waits, input int bp, input int gap);
      bit timed_out;
      int n_access;
      timed_out = (TMO > 0) && (waits >= TMO);
      n_access  = timed_out ? TMO : waits + 1;
      for (int i = 0; i <= gap; i++) begin
         junk();
         rsp_ready = 1'($urandom);
         cmd_valid = (i == gap);
         cmd_write = wr;
         cmd_addr  = addr;
         cmd_wdata = wdata;
         cmd_strb  = strb;
         cmd_prot  = prot;
         set_exp(1'b1, 1'b0, 1'b0, 1'b0);
         if (i == gap) begin
            acc_cyc  = cyc;
            pen_mark = pen_total;
         end
         tick();
      end
      set_fields(wr, addr, wdata, strb, prot);
      cmd_valid = 1'b0;
      junk();
      set_exp(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      for (int i = 1; i <= n_access; i++) begin
         PREADY  = (i == waits + 1);
         PRDATA  = PREADY ? rdata : $urandom;
         PSLVERR = PREADY ? serr : 1'($urandom);
         set_exp(1'b0, 1'b1, 1'b1, 1'b0);
         tick();
      end
      e_rdata  = (timed_out || wr) ? '0 : rdata;
      e_slverr = timed_out ? 1'b1 : serr;
      e_to     = timed_out;
      for (int r = 0; r <= bp; r++) begin
         junk();
         rsp_ready = (r == bp);
         cmd_valid = (r < bp);
         cmd_write = 1'($urandom);
         cmd_addr  = $urandom;
         cmd_wdata = $urandom;
         cmd_strb  = SW'($urandom);
         cmd_prot  = 3'($urandom);
         set_exp(1'b0, 1'b0, 1'b0, 1'b1);
         tick();
      end
      cmd_valid = 1'b0;
   endtask

   task automatic reset_mid_access();
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'h0000_0070;
      cmd_wdata = 32'h0BAD_CAFE;
      cmd_strb  = 4'hC;
      cmd_prot  = 3'b011;
      rsp_ready = 1'b0;
      junk();
      set_exp(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      set_fields(1'b1, 32'h0000_0070, 32'h0BAD_CAFE, 4'hC, 3'b011);
      cmd_valid = 1'b0;
      set_exp(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 2; i++) begin
         PREADY = 1'b0;
         set_exp(1'b0, 1'b1, 1'b1, 1'b0);
         if (i == 0) tick();
      end
      #2 PRESET = 1'b1;
      #1;
      check("rst_async_psel", PSELx, 1'b0);
      check("rst_async_penable", PENABLE, 1'b0);
      check("rst_async_cmd_ready", cmd_ready, 1'b1);
      set_exp(1'b1, 1'b0, 1'b0, 1'b0);
      set_fields(1'b0, '0, '0, '0, 3'b000);
      tick();
      PRESET = 1'b0;
      for (int i = 0; i < 3; i++) begin
         junk();
         rsp_ready = 1'b1;
         tick();
      end
   endtask

   initial begin
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0;
      PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
      e_rdata = '0; e_slverr = 1'b0; e_to = 1'b0;
      set_exp(1'b1, 1'b0, 1'b0, 1'b0);
      set_fields(1'b0, '0, '0, '0, 3'b000);
      tick();
      tick();
      check("reset_cmd_ready", cmd_ready, 1'b1);
      check("reset_psel", PSELx, 1'b0);
      check("reset_rsp_valid", rsp_valid, 1'b0);
      check("reset_paddr", PADDR, 32'h0);
      PRESET = 1'b0;

      run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b000, 32'h0BAD_0BAD, 1'b0, 0, 0, 1);
      check("wr0_latency", rsp_rise_cyc - acc_cyc, 3);
      check("wr0_access_cycles", pen_total - pen_mark, 1);
      check("wr0_rdata", obs_rdata, 32'h0);
      check("wr0_slverr", obs_slverr, 1'b0);

      run_txn(1'b0, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 3'b010, 32'h1234_5678, 1'b0, 3, 0, 1);
      check("rd3_latency", rsp_rise_cyc - acc_cyc, 6);
      check("rd3_access_cycles", pen_total - pen_mark, 4);
      check("rd3_rdata", obs_rdata, 32'h1234_5678);
      check("rd3_pstrb_zero", rd_strb_bad, 0);

      run_txn(1'b1, 32'h0000_0030, 32'h5555_AAAA, 4'h3, 3'b001, 32'h0, 1'b1, 1, 0, 0);
      check("err_slverr", obs_slverr, 1'b1);
      check("err_timeout", obs_to, 1'b0);

      run_txn(1'b0, 32'h0000_0040, 32'h0, 4'h0, 3'b000, 32'h7777_7777, 1'b0, 50, 0, 1);
      check("tmo_access_cycles", pen_total - pen_mark, 4);
      check("tmo_latency", rsp_rise_cyc - acc_cyc, 6);
      check("tmo_timeout", obs_to, 1'b1);
      check("tmo_slverr", obs_slverr, 1'b1);
      check("tmo_rdata", obs_rdata, 32'h0);

      run_txn(1'b0, 32'h0000_0044, 32'h0, 4'h0, 3'b000, 32'hA5A5_0F0F, 1'b0, 3, 0, 1);
      check("lim_access_cycles", pen_total - pen_mark, 4);
      check("lim_timeout", obs_to, 1'b0);
      check("lim_rdata", obs_rdata, 32'hA5A5_0F0F);

      run_txn(1'b1, 32'h0000_0050, 32'h0102_0304, 4'h5, 3'b111, 32'h0, 1'b0, 0, 5, 1);
      check("bp_latency", rsp_rise_cyc - acc_cyc, 3);

      reset_mid_access();
      run_txn(1'b0, 32'h0000_0060, 32'h0, 4'h0, 3'b000, 32'hFEED_F00D, 1'b0, 1, 1, 0);
      check("post_rst_rdata", obs_rdata, 32'hFEED_F00D);

      for (int t = 0; t < 60; t++) begin
         run_txn(1'($urandom), $urandom, $urandom, SW'($urandom), 3'($urandom), $urandom,
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 6), $urandom_range(0, 3),
                 $urandom_range(0, 2));
      end
      check("read_pstrb_never_set", rd_strb_bad, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1);
   end

endmodule
